// File: rtl/halt_pkg.sv
// Shared types and defaults for the halt sequencer slice.
package halt_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_e;

  localparam int CNT_W_DEFAULT = 32;

  // Drain counter width; never narrower than one bit, even with no drain.
  function automatic int drain_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/halt_sequencer_wrap_counter.sv
// Free-running wrapping event counter used for the performance counters.
module wrap_counter
  import halt_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count qualified events, wrapping modulo 2^W.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc) begin
      q <= q + W'(1'b1);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/halt_sequencer.sv
// Turns the level halt flag into an orderly drain-then-freeze of the core,
// and keeps cycle / retired-instruction counts for the non-halted time.
module halt_sequencer
  import halt_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_i,
  input  logic             retire_i,
  output logic             stall_o,
  output logic             halted_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_cnt_o
);

  localparam int DW = drain_w(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);

  halt_state_e   state_r;
  halt_state_e   state_nxt_s;
  logic [DW-1:0] drain_cnt_r;
  logic [DW-1:0] drain_cnt_nxt_s;
  logic          done_r;
  logic          active_s;
  logic          retire_en_s;

  // Next-state and drain counter logic.
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    case (state_r)
      RUN: begin
        if (halt_i) begin
          if (DRAIN_CYCLES >= 1) begin
            state_nxt_s     = DRAIN;
            drain_cnt_nxt_s = DRAIN_LOAD;
          end else begin
            state_nxt_s = HALTED;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (!halt_i) begin
          state_nxt_s     = RUN;
          drain_cnt_nxt_s = '0;
        end else if (drain_cnt_r == '0) begin
          state_nxt_s = HALTED;
        end else begin
          drain_cnt_nxt_s = drain_cnt_r - DW'(1'b1);
        end
      end
      HALTED: begin
        if (!halt_i) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = HALTED;
        end
      end
      default: begin
        state_nxt_s     = RUN;
        drain_cnt_nxt_s = '0;
      end
    endcase
  end

  // State, drain counter and the completion pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      drain_cnt_r <= '0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
      done_r      <= (state_nxt_s == HALTED) && (state_r != HALTED);
    end
  end

  assign active_s    = (state_r != HALTED);
  assign retire_en_s = retire_i && active_s;

  assign stall_o  = (state_r == DRAIN) || (state_r == HALTED);
  assign halted_o = (state_r == HALTED);
  assign done_o   = done_r;

  wrap_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .inc (active_s),
    .q   (cycle_cnt_o)
  );

  wrap_counter #(.W(CNT_W)) u_instret_cnt (
    .clk (clk),
    .rst (rst),
    .inc (retire_en_s),
    .q   (instret_cnt_o)
  );

endmodule
